// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/ack and downstream instruction handshake bundle
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc, halted,
    input  imem_ack, imem_data, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc, halted,
    output imem_ack, imem_data, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetcher with a 2-entry buffer, branch drain and HALT
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] fpc;
  logic [15:0] req_addr;
  logic        outstanding;
  logic        started;
  logic [15:0] fifo_addr [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        head_valid;
  logic        pop;
  logic        halt_pop;
  logic        branch_live;
  logic        ack_live;
  logic        push;
  logic        flush;
  logic        issue;

  always_comb begin
    head_valid  = (count != 2'd0);
    pop         = head_valid && !bus.stall;
    halt_pop    = pop && (fifo_data[rd_ptr][31:24] == 8'h0D);
    // HALT consumption wins over a branch arriving in the same cycle
    branch_live = bus.branch_taken && (state != HALT) && !halt_pop;
    ack_live    = bus.imem_ack && outstanding;
    push        = ack_live && (state == RUN) && !branch_live && !halt_pop;
    flush       = branch_live || halt_pop;
    issue       = started && (state == RUN) && !outstanding &&
                  (count < 2'd2) && !bus.branch_taken;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (halt_pop)
          state_nxt = HALT;
        else if (branch_live && outstanding && !bus.imem_ack)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (halt_pop)
          state_nxt = HALT;
        else if (bus.imem_ack)
          state_nxt = RUN;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      started     <= 1'b0;
      fpc         <= RESET_PC;
      req_addr    <= RESET_PC;
      outstanding <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (issue) begin
        outstanding <= 1'b1;
        req_addr    <= fpc;
      end else if (ack_live) begin
        outstanding <= 1'b0;
      end
      if (branch_live)
        fpc <= bus.branch_target;
      else if (issue)
        fpc <= fpc + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_addr[0] <= 16'h0000;
      fifo_addr[1] <= 16'h0000;
      fifo_data[0] <= 32'h0000_0000;
      fifo_data[1] <= 32'h0000_0000;
    end else if (push) begin
      fifo_addr[wr_ptr] <= req_addr;
      fifo_data[wr_ptr] <= bus.imem_data;
    end
  end

  // The request line stays up with a stable address until its ack, including a discarded one
  assign bus.imem_req    = issue || (outstanding && (state != HALT));
  assign bus.imem_addr   = outstanding ? req_addr : fpc;
  assign bus.instr_valid = head_valid;
  assign bus.instruction = head_valid ? fifo_data[rd_ptr] : 32'h0000_0000;
  assign bus.pc          = head_valid ? fifo_addr[rd_ptr] : 16'h0000;
  assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized fetch_unit bench against a program-order reference model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(16'h0000)) dut      (.clk(clk), .reset(reset), .bus(bus));
  fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (.clk(clk), .reset(reset), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_pc, next_fetch, halt_addr, mem_addr, hold_pc;
  logic [31:0] hold_instr;
  logic        halted_m, halt_en, mem_busy, prev_flush, prev_hold;
  logic        spur_en, force_junk, pend2, last_issue, last_br;
  int          mem_cnt, lat_fix, issued_since, consumed_since, idle, n_consumed;
  logic [15:0] log_pc[$];
  logic [15:0] log_addr2[$];
  logic [15:0] log_pc2[$];

  // Program image: every word is addr+0x100 except an optional planted HALT
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr)
      return 32'h0D00_0000;
    return {16'h0000, a} + 32'h0000_0100;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_pc = 16'h0000; next_fetch = 16'h0000; halted_m = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; prev_flush = 1'b0; prev_hold = 1'b0;
    issued_since = 0; consumed_since = 0; idle = 0; pend2 = 1'b0;
    log_pc.delete(); log_addr2.delete(); log_pc2.delete();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_req",       64'(bus.imem_req),    64'd0);
    chk("rst_addr",      64'(bus.imem_addr),   64'h0000);
    chk("rst_instr",     64'(bus.instruction), 64'd0);
    chk("rst_pc",        64'(bus.pc),          64'd0);
    chk("rst_valid",     64'(bus.instr_valid), 64'd0);
    chk("rst_halted",    64'(bus.halted),      64'd0);
    chk("rst_wrap_addr", 64'(bus2.imem_addr),  64'hFFFF);
    bus.imem_ack = 1'b1; bus.imem_data = 32'hDEAD_BEEF;
    bus.branch_taken = 1'b0; bus.stall = 1'b0; bus2.imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.imem_ack = 1'b0; bus2.imem_ack = 1'b0;
    model_clear();
    force_junk = 1'b1;
  endtask

  task automatic step(input logic st, input logic br, input logic [15:0] tgt, input logic br_on_ack);
    logic ack_now, new_issue, cons, halt_now, br_eff;
    @(posedge clk);
    #1;
    ack_now = mem_busy && (mem_cnt == 0);
    bus.imem_ack  = ack_now;
    bus.imem_data = ack_now ? mem_word(mem_addr) : $urandom();
    if (force_junk) begin
      bus.imem_ack = 1'b1; bus.imem_data = 32'hDEAD_BEEF; force_junk = 1'b0;
    end else if (!mem_busy && spur_en && $urandom_range(0, 15) == 0) begin
      bus.imem_ack = 1'b1;
    end
    bus.stall         = st;
    bus.branch_taken  = br || (br_on_ack && ack_now);
    bus.branch_target = tgt;
    bus2.imem_ack     = pend2;
    bus2.imem_data    = {16'h0000, bus2.imem_addr} + 32'h0000_0100;
    @(negedge clk);

    chk("halted", 64'(bus.halted), 64'(halted_m));
    if (halted_m) begin
      chk("halt_req",   64'(bus.imem_req),    64'd0);
      chk("halt_valid", 64'(bus.instr_valid), 64'd0);
    end
    if (prev_flush)
      chk("flush", 64'(bus.instr_valid), 64'd0);
    if (prev_hold)
      chk("hold", {15'd0, bus.instr_valid, bus.pc, bus.instruction},
                  {15'd0, 1'b1, hold_pc, hold_instr});

    new_issue  = bus.imem_req && !mem_busy;
    last_issue = new_issue;
    if (bus.imem_req && mem_busy)
      chk("addr_hold", 64'(bus.imem_addr), 64'(mem_addr));
    if (new_issue) begin
      chk("issue_addr",   64'(bus.imem_addr),    64'(next_fetch));
      chk("issue_no_br",  64'(bus.branch_taken), 64'd0);
      chk("depth",        64'(issued_since - consumed_since <= 1), 64'd1);
      mem_busy = 1'b1; mem_addr = bus.imem_addr;
      mem_cnt = (lat_fix != 0) ? lat_fix - 1 : int'($urandom_range(0, 2));
      issued_since++;
      next_fetch = next_fetch + 16'd1;
    end else if (mem_busy && !ack_now) begin
      mem_cnt--;
    end
    if (ack_now)
      mem_busy = 1'b0;

    cons = bus.instr_valid && !st;
    halt_now = 1'b0;
    if (cons) begin
      chk("pc",    64'(bus.pc),          64'(exp_pc));
      chk("instr", 64'(bus.instruction), 64'(mem_word(exp_pc)));
      log_pc.push_back(bus.pc);
      halt_now = halt_en && (exp_pc == halt_addr);
      exp_pc = exp_pc + 16'd1;
      consumed_since++; n_consumed++; idle = 0;
    end else if (!st && !halted_m) begin
      idle++;
      chk("progress", 64'(idle <= 12), 64'd1);
    end

    br_eff  = bus.branch_taken && !halted_m && !halt_now;
    last_br = br_eff;
    if (br_eff) begin
      exp_pc = tgt; next_fetch = tgt;
      issued_since = 0; consumed_since = 0; idle = 0;
    end
    prev_flush = br_eff || halt_now;
    prev_hold  = bus.instr_valid && st && !br_eff && !halted_m;
    hold_pc    = bus.pc;
    hold_instr = bus.instruction;
    if (halt_now)
      halted_m = 1'b1;

    if (bus2.imem_req && !pend2)
      log_addr2.push_back(bus2.imem_addr);
    if (bus2.instr_valid)
      log_pc2.push_back(bus2.pc);
    pend2 = bus2.imem_req && !pend2;
  endtask

  initial begin
    int base, idx;
    bus.imem_ack = 1'b0; bus.imem_data = 32'h0; bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 16'h0;
    bus2.imem_ack = 1'b0; bus2.imem_data = 32'h0; bus2.stall = 1'b0;
    bus2.branch_taken = 1'b0; bus2.branch_target = 16'h0;
    halt_en = 1'b0; halt_addr = 16'h0; lat_fix = 1; spur_en = 1'b0;
    force_junk = 1'b0; n_consumed = 0; last_issue = 1'b0; last_br = 1'b0;
    model_clear();
    do_reset();

    // Linear fetch with one-cycle ack
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    base = n_consumed;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("throughput", 64'(n_consumed - base >= 9), 64'd1);
    chk("linear_cnt", 64'(log_pc.size() >= 4), 64'd1);
    if (log_pc.size() >= 4)
      for (int i = 0; i < 4; i++) chk("linear_pc", 64'(log_pc[i]), 64'(i));
    chk("wrap_cnt", 64'(log_addr2.size() >= 2 && log_pc2.size() >= 2), 64'd1);
    if (log_addr2.size() >= 2 && log_pc2.size() >= 2) begin
      chk("wrap_addr0", 64'(log_addr2[0]), 64'hFFFF);
      chk("wrap_addr1", 64'(log_addr2[1]), 64'h0000);
      chk("wrap_pc0",   64'(log_pc2[0]),   64'hFFFF);
      chk("wrap_pc1",   64'(log_pc2[1]),   64'h0000);
    end

    // Backpressure
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("full_req",   64'(bus.imem_req),    64'd0);
    chk("full_valid", 64'(bus.instr_valid), 64'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b0);

    // Branch while a slow request is in flight
    lat_fix = 3;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      if (last_issue) break;
    end
    chk("p3_issue", 64'(last_issue), 64'd1);
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    idx = log_pc.size();
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("p3_cnt", 64'(log_pc.size() > idx), 64'd1);
    if (log_pc.size() > idx) chk("p3_target", 64'(log_pc[idx]), 64'h0040);

    // Branch landing on the ack cycle
    lat_fix = 2;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h0123, 1'b1);
      if (last_br) break;
    end
    chk("p4_branch", 64'(last_br), 64'd1);
    idx = log_pc.size();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("p4_cnt", 64'(log_pc.size() > idx), 64'd1);
    if (log_pc.size() > idx) chk("p4_target", 64'(log_pc[idx]), 64'h0123);

    // Randomized traffic
    lat_fix = 0; spur_en = 1'b1;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           16'($urandom()), $urandom_range(0, 7) == 0);
    spur_en = 1'b0; lat_fix = 1;
    do_reset();

    // HALT
    halt_en = 1'b1; halt_addr = 16'd5;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      if (halted_m) break;
    end
    chk("halt_reached", 64'(halted_m), 64'd1);
    for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b1, 16'h0040, 1'b0);
    do_reset();
    halt_en = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
